multi_ring_tuner_sweep: RTL

MULTI_RING_TUNER_SWEEP -- requirements
Module: multi_ring_tuner_sweep

---
 rtl/multi_ring_tuner_sweep_if.sv | 29 ++
 rtl/multi_ring_tuner_sweep.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multi_ring_tuner_sweep_if.sv
// rtl/multi_ring_tuner_sweep_if.sv - control and per-ring data bundle for the microring tuner sweep
interface multi_ring_tuner_sweep_if #(
  parameter int NUM_RINGS = 4,
  parameter int DAC_WIDTH = 8,
  parameter int ADC_WIDTH = 8
);
  localparam int IDX_W = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1;

  logic                           i_start;
  logic                           i_abort;
  logic                           i_search_max;
  logic [NUM_RINGS*ADC_WIDTH-1:0] i_adc;
  logic [NUM_RINGS*DAC_WIDTH-1:0] o_dac;
  logic                           o_busy;
  logic                           o_done;
  logic [IDX_W-1:0]               o_ring_idx;
  logic [NUM_RINGS*DAC_WIDTH-1:0] o_lock_code;
  logic [NUM_RINGS*ADC_WIDTH-1:0] o_lock_pwr;

  modport master (
    output i_start, i_abort, i_search_max, i_adc,
    input  o_dac, o_busy, o_done, o_ring_idx, o_lock_code, o_lock_pwr
  );

  modport slave (
    input  i_start, i_abort, i_search_max, i_adc,
    output o_dac, o_busy, o_done, o_ring_idx, o_lock_code, o_lock_pwr
  );
endinterface

// File: rtl/multi_ring_tuner_sweep.sv
// rtl/multi_ring_tuner_sweep.sv - sequential DAC sweep of each microring, locking to the min/max power code
module multi_ring_tuner_sweep #(
  parameter int NUM_RINGS     = 4,
  parameter int DAC_WIDTH     = 8,
  parameter int ADC_WIDTH     = 8,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  multi_ring_tuner_sweep_if.slave bus
);
  localparam int IDX_W = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DAC_WIDTH:0] CODE_MAX = (DAC_WIDTH+1)'((1 << DAC_WIDTH) - 1);
  localparam logic [DAC_WIDTH:0] STEP_W   = (DAC_WIDTH+1)'(STEP);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t state, state_nxt;

  logic [DAC_WIDTH-1:0] dac_q       [NUM_RINGS];
  logic [DAC_WIDTH-1:0] lock_code_q [NUM_RINGS];
  logic [ADC_WIDTH-1:0] lock_pwr_q  [NUM_RINGS];

  logic [IDX_W-1:0]     ring_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DAC_WIDTH-1:0] code_q;
  logic [DAC_WIDTH-1:0] best_code_q;
  logic [ADC_WIDTH-1:0] best_pwr_q;
  logic [DAC_WIDTH-1:0] saved_dac_q;
  logic                 first_q;
  logic                 mode_max_q;

  logic [ADC_WIDTH-1:0] cur_adc;
  logic                 better;
  logic [DAC_WIDTH-1:0] eff_code;
  logic [ADC_WIDTH-1:0] eff_pwr;
  logic [DAC_WIDTH:0]   code_next;
  logic                 code_more;
  logic                 last_ring;
  logic                 settle_end;
  logic [IDX_W-1:0]     ring_inc;

  always_comb begin
    cur_adc    = bus.i_adc[int'(ring_q)*ADC_WIDTH +: ADC_WIDTH];
    // strict compare keeps the lowest code on ties
    better     = first_q || (mode_max_q ? (cur_adc > best_pwr_q) : (cur_adc < best_pwr_q));
    eff_code   = better ? code_q  : best_code_q;
    eff_pwr    = better ? cur_adc : best_pwr_q;
    code_next  = {1'b0, code_q} + STEP_W;
    code_more  = (code_next <= CODE_MAX);
    last_ring  = (ring_q == IDX_W'(NUM_RINGS - 1));
    settle_end = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
    ring_inc   = ring_q + IDX_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_start) state_nxt = SETTLE;
      SETTLE:  if (bus.i_abort) state_nxt = IDLE;
               else if (settle_end) state_nxt = SAMPLE;
      SAMPLE:  if (bus.i_abort) state_nxt = IDLE;
               else if (code_more || !last_ring) state_nxt = SETTLE;
               else state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_RINGS; r++) begin
        dac_q[r]       <= '0;
        lock_code_q[r] <= '0;
        lock_pwr_q[r]  <= '0;
      end
      ring_q      <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      best_code_q <= '0;
      best_pwr_q  <= '0;
      saved_dac_q <= '0;
      first_q     <= 1'b0;
      mode_max_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_start) begin
          ring_q      <= '0;
          cnt_q       <= '0;
          code_q      <= '0;
          first_q     <= 1'b1;
          mode_max_q  <= bus.i_search_max;
          saved_dac_q <= dac_q[0];
          dac_q[0]    <= '0;
        end
        SETTLE: begin
          if (bus.i_abort) dac_q[ring_q] <= saved_dac_q;
          else if (settle_end) cnt_q <= '0;
          else cnt_q <= cnt_q + CNT_W'(1);
        end
        SAMPLE: begin
          if (bus.i_abort) begin
            dac_q[ring_q] <= saved_dac_q;
          end else begin
            best_code_q <= eff_code;
            best_pwr_q  <= eff_pwr;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            if (code_more) begin
              code_q        <= code_next[DAC_WIDTH-1:0];
              dac_q[ring_q] <= code_next[DAC_WIDTH-1:0];
            end else begin
              dac_q[ring_q]       <= eff_code;
              lock_code_q[ring_q] <= eff_code;
              lock_pwr_q[ring_q]  <= eff_pwr;
              if (!last_ring) begin
                // the next ring restarts from code 0; remember its old DAC for abort
                ring_q          <= ring_inc;
                code_q          <= '0;
                first_q         <= 1'b1;
                saved_dac_q     <= dac_q[ring_inc];
                dac_q[ring_inc] <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < NUM_RINGS; r++) begin : g_pack
    assign bus.o_dac[r*DAC_WIDTH +: DAC_WIDTH]       = dac_q[r];
    assign bus.o_lock_code[r*DAC_WIDTH +: DAC_WIDTH] = lock_code_q[r];
    assign bus.o_lock_pwr[r*ADC_WIDTH +: ADC_WIDTH]  = lock_pwr_q[r];
  end

  assign bus.o_busy     = (state == SETTLE) || (state == SAMPLE);
  assign bus.o_done     = (state == DONE);
  assign bus.o_ring_idx = ring_q;
endmodule
